sram_req_sequencer: RTL and testbench

- Upstream request sequencer for the 4-word x 2-bit asynchronous storage array.
- Accepts single-word read/write requests from a client over a valid/ready handshake.
- Drives the array's word select, chip select, write enable and data lines in a glitch-safe setup/strobe/release sequence.
- Returns a one-cycle response; read data is captured from the array output.

---
 rtl/sram_req_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_sram_req_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_sequencer.sv
// sram_req_sequencer
//   Upstream request sequencer for a small asynchronous storage array.
//   It accepts single-word read/write requests over a valid/ready handshake
//   and drives the array in a glitch-safe setup / strobe / release sequence.
//   It then returns a one-cycle response. Every output is a flop.
//
// Parameters
//   DW        data word width
//   AW        word-select width (2**AW words)
//   WAIT_CYC  strobe length in clk cycles (1..15; 0 behaves as 1)
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_we/addr/wdata        request fields, latched at acceptance
//   rsp_valid/rsp_we/rdata   one-cycle response; rdata holds until next read
//   rsp_err                  write-verify mismatch (optional feature only)
//   mem_sel/cs/we/d          array word select, enable, write enable, data
//   mem_q                    array read data
//
// Optional feature macro: SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
//   When defined, each write reads the word back for WAIT_CYC cycles after
//   RELEASE and reports a mismatch on rsp_err.
module sram_req_sequencer #(
  parameter int unsigned DW       = 2,
  parameter int unsigned AW       = 2,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
  output logic          rsp_err,
`endif
  output logic [AW-1:0] mem_sel,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  localparam int unsigned WC = (WAIT_CYC == 0) ? 1 : ((WAIT_CYC > 15) ? 15 : WAIT_CYC);
  localparam logic [3:0]  CNT_LOAD = 4'(WC - 1);

`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] sel_d;
  logic [DW-1:0] wd_d;
  logic          ready_d, cs_d, we_d;
  logic          rsp_valid_d, rsp_we_d;
  logic [DW-1:0] rsp_rdata_d;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
  logic          ver_q, ver_d;
  logic          err_d;
`endif

  // mem_sel / mem_d are the latched request fields themselves. They only
  // change on the acceptance edge, when mem_cs and mem_we are both low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_we_q  <= 1'b0;
      mem_sel   <= '0;
      mem_d     <= '0;
      req_ready <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
      ver_q     <= 1'b0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_we_q  <= lat_we_d;
      mem_sel   <= sel_d;
      mem_d     <= wd_d;
      req_ready <= ready_d;
      mem_cs    <= cs_d;
      mem_we    <= we_d;
      rsp_valid <= rsp_valid_d;
      rsp_we    <= rsp_we_d;
      rsp_rdata <= rsp_rdata_d;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
      ver_q     <= ver_d;
      rsp_err   <= err_d;
`endif
    end
  end

  // Output flops are loaded from the values that belong to the next state.
  // This keeps every output registered while each state still has its own
  // output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    sel_d       = mem_sel;
    wd_d        = mem_d;
    ready_d     = 1'b0;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we;
    rsp_rdata_d = rsp_rdata;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
    ver_d       = ver_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = SETUP;
          lat_we_d = req_we;
          sel_d    = req_addr;
          wd_d     = req_wdata;
          cs_d     = 1'b1;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
          ver_d    = 1'b0;
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
        cs_d    = 1'b1;
        we_d    = lat_we_q;
      end
      STROBE: begin
        cs_d = 1'b1;
        if (cnt_q == '0) begin
          state_d  = RELEASE;
          rsp_we_d = lat_we_q;
          if (!lat_we_q) rsp_rdata_d = mem_q;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
          rsp_valid_d = !lat_we_q;
`else
          rsp_valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
          we_d  = lat_we_q;
        end
      end
      RELEASE: begin
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
        // A write passes through RELEASE twice. The first pass leads into
        // the read-back. The second pass (ver_q set) is the response cycle.
        if (lat_we_q && !ver_q) begin
          state_d = VERIFY;
          cnt_d   = CNT_LOAD;
          cs_d    = 1'b1;
        end else
`endif
        begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
      VERIFY: begin
        cs_d = 1'b1;
        if (cnt_q == '0) begin
          state_d     = RELEASE;
          ver_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          err_d       = (mem_q != mem_d);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_req_sequencer.sv
// tb_sram_req_sequencer
//   Bench for sram_req_sequencer. It has two instances, WAIT_CYC=1 and
//   WAIT_CYC=3, and each instance has its own behavioural storage array.
//   A request table and hand-written corner sequences drive the instances.
//   Expected responses go into a scoreboard queue and are checked when
//   rsp_valid appears.
module tb_sram_req_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = '0;
  logic [1:0] req_wdata = '0;
  logic       req_valid1 = 1'b0;
  logic       req_valid3 = 1'b0;
  logic       force_q = 1'b0;
  logic       tsel = 1'b0;

  logic       r1_ready, r1_rv, r1_rwe, m1_cs, m1_we;
  logic [1:0] r1_rd, m1_sel, m1_d, m1_q;
  logic       r3_ready, r3_rv, r3_rwe, m3_cs, m3_we;
  logic [1:0] r3_rd, m3_sel, m3_d, m3_q;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
  logic       r1_err, r3_err, cur_err;
  assign cur_err = tsel ? r3_err : r1_err;
`endif

  always #5 clk = ~clk;

  sram_req_sequencer #(.DW(2), .AW(2), .WAIT_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(r1_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_rv), .rsp_we(r1_rwe), .rsp_rdata(r1_rd),
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
    .rsp_err(r1_err),
`endif
    .mem_sel(m1_sel), .mem_cs(m1_cs), .mem_we(m1_we), .mem_d(m1_d), .mem_q(m1_q)
  );

  sram_req_sequencer #(.DW(2), .AW(2), .WAIT_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(r3_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_rv), .rsp_we(r3_rwe), .rsp_rdata(r3_rd),
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
    .rsp_err(r3_err),
`endif
    .mem_sel(m3_sel), .mem_cs(m3_cs), .mem_we(m3_we), .mem_d(m3_d), .mem_q(m3_q)
  );

  // Behavioural storage arrays. A write takes place at each clock edge where
  // cs and we are both high. The read path forces 2'b01 when force_q is set.
  logic [1:0] arr1 [4] = '{default: '0};
  logic [1:0] arr3 [4] = '{default: '0};
  always @(posedge clk) begin
    if (m1_cs && m1_we) arr1[m1_sel] <= m1_d;
    if (m3_cs && m3_we) arr3[m3_sel] <= m3_d;
  end
  assign m1_q = (m1_cs && !m1_we) ? (force_q ? 2'b01 : arr1[m1_sel]) : 2'b00;
  assign m3_q = (m3_cs && !m3_we) ? (force_q ? 2'b01 : arr3[m3_sel]) : 2'b00;

  logic       cur_ready, cur_rv, cur_rwe, cur_cs, cur_we;
  logic [1:0] cur_rd, cur_sel, cur_d;
  assign cur_ready = tsel ? r3_ready : r1_ready;
  assign cur_rv    = tsel ? r3_rv    : r1_rv;
  assign cur_rwe   = tsel ? r3_rwe   : r1_rwe;
  assign cur_rd    = tsel ? r3_rd    : r1_rd;
  assign cur_cs    = tsel ? m3_cs    : m1_cs;
  assign cur_we    = tsel ? m3_we    : m1_we;
  assign cur_sel   = tsel ? m3_sel   : m1_sel;
  assign cur_d     = tsel ? m3_d     : m1_d;

  // Glitch monitor. While mem_we is high, sel/d must match their values
  // from the previous cycle.
  int         glitch_viol = 0;
  logic [1:0] ps1 = '0, pd1 = '0, ps3 = '0, pd3 = '0;
  always @(negedge clk) begin
    if (m1_we && (m1_sel != ps1 || m1_d != pd1)) glitch_viol++;
    if (m3_we && (m3_sel != ps3 || m3_d != pd3)) glitch_viol++;
    ps1 = m1_sel; pd1 = m1_d; ps3 = m3_sel; pd3 = m3_d;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (dut W=%0d): got %0d, expected %0d", nm, tsel ? 3 : 1, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  rdata;
    int unsigned lat;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [1:0] last_rd [2] = '{default: '0};

  // Must be called right after a falling edge. It drives one request,
  // follows it to the response, and ends at the falling edge of the first
  // cycle after the response.
  task automatic do_req(input logic we, input logic [1:0] addr, input logic [1:0] wd,
                        input logic [1:0] exp_rd, input logic chg, input logic exp_err);
    int unsigned w;
    int          n, first_we, we_cnt, rsp_c;
    logic        got;
    exp_t        e;
    w = tsel ? 3 : 1;
    e.we    = we;
    e.rdata = we ? last_rd[tsel] : exp_rd;
    e.lat   = 2 + w;
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
    if (we) e.lat = 3 + 2 * w;
`endif
    e.err = exp_err;
    sb.push_back(e);
    if (!we) last_rd[tsel] = exp_rd;

    req_we = we; req_addr = addr; req_wdata = wd;
    if (tsel) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    n = 0;
    while (!cur_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(cur_ready), 1);
    @(negedge clk);
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    first_we = 0; we_cnt = 0; rsp_c = 0; got = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2 && chg) begin req_addr = ~addr; req_wdata = ~wd; end
      if (cur_we) begin
        we_cnt++;
        if (first_we == 0) first_we = c;
      end
      if (cur_rv) begin got = 1'b1; rsp_c = c; break; end
      @(negedge clk);
    end
    e = sb.pop_front();
    check("rsp_seen", 32'(got), 1);
    if (got) begin
      check("rsp_latency", 32'(rsp_c), e.lat);
      check("rsp_we", 32'(cur_rwe), 32'(e.we));
      check("rsp_rdata", 32'(cur_rd), 32'(e.rdata));
      check("ready_in_rsp", 32'(cur_ready), 0);
      check("cs_in_rsp", 32'(cur_cs), 1);
`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
      check("rsp_err", 32'(cur_err), 32'(e.err));
`endif
      if (we) begin
        check("we_first_cycle", 32'(first_we), 2);
        check("we_length", 32'(we_cnt), w);
      end else begin
        check("we_on_read", 32'(we_cnt), 0);
      end
      @(negedge clk);
      check("ready_after_rsp", 32'(cur_ready), 1);
      check("cs_after_rsp", 32'(cur_cs), 0);
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [1:0] wd;
    logic [1:0] rd;
  } vec_t;
  vec_t tbl [10];

  int rv_seen;

  initial begin
    tbl[0] = '{1'b1, 2'd2, 2'b10, 2'b00};
    tbl[1] = '{1'b0, 2'd2, 2'b00, 2'b10};
    tbl[2] = '{1'b1, 2'd0, 2'b01, 2'b00};
    tbl[3] = '{1'b1, 2'd1, 2'b10, 2'b00};
    tbl[4] = '{1'b1, 2'd2, 2'b11, 2'b00};
    tbl[5] = '{1'b1, 2'd3, 2'b00, 2'b00};
    tbl[6] = '{1'b0, 2'd0, 2'b00, 2'b01};
    tbl[7] = '{1'b0, 2'd1, 2'b00, 2'b10};
    tbl[8] = '{1'b0, 2'd2, 2'b00, 2'b11};
    tbl[9] = '{1'b0, 2'd3, 2'b00, 2'b00};

    // Reset state of both instances
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      tsel = s[0];
      #1;
      check("rst_ready", 32'(cur_ready), 0);
      check("rst_rsp_valid", 32'(cur_rv), 0);
      check("rst_rsp_we", 32'(cur_rwe), 0);
      check("rst_rdata", 32'(cur_rd), 0);
      check("rst_cs", 32'(cur_cs), 0);
      check("rst_we", 32'(cur_we), 0);
      check("rst_sel", 32'(cur_sel), 0);
      check("rst_d", 32'(cur_d), 0);
    end
    tsel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(r1_ready), 1);
    check("cs_after_release", 32'(m1_cs), 0);
    check("ready3_after_release", 32'(r3_ready), 1);

    // Write/read and the all-address sweep, WAIT_CYC=1
    tsel = 1'b0;
    for (int i = 0; i < 10; i++)
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rd, 1'b0, 1'b0);

    // WAIT_CYC=3: request fields change mid-strobe, only latched values land
    tsel = 1'b1;
    do_req(1'b1, 2'd1, 2'b11, 2'b00, 1'b1, 1'b0);
    do_req(1'b0, 2'd1, 2'b00, 2'b11, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset abort in the middle of a write strobe
    req_we = 1'b1; req_addr = 2'd0; req_wdata = 2'b10; req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    check("abort_we_before", 32'(m3_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_drop", 32'(m3_we), 0);
    check("abort_cs_drop", 32'(m3_cs), 0);
    check("abort_ready_low", 32'(r3_ready), 0);
    rv_seen = 0;
    repeat (2) begin @(negedge clk); if (r3_rv) rv_seen++; end
    rst_n = 1'b1;
    last_rd[0] = 2'b00;
    last_rd[1] = 2'b00;
    @(negedge clk);
    check("abort_ready_after", 32'(r3_ready), 1);
    repeat (3) begin
      if (r3_rv) rv_seen++;
      @(negedge clk);
    end
    check("abort_no_rsp", 32'(rv_seen), 0);
    do_req(1'b0, 2'd1, 2'b00, 2'b11, 1'b0, 1'b0);

`ifdef SRAM_REQ_SEQUENCER_WRITE_VERIFY_EN
    // Write verify: mismatch forced on the read-back, then a clean write
    tsel = 1'b0;
    force_q = 1'b1;
    do_req(1'b1, 2'd3, 2'b11, 2'b00, 1'b0, 1'b1);
    force_q = 1'b0;
    do_req(1'b1, 2'd3, 2'b01, 2'b00, 1'b0, 1'b0);
    do_req(1'b0, 2'd3, 2'b00, 2'b01, 1'b0, 1'b0);
`endif

    check("glitch_violations", 32'(glitch_viol), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
